mem_arbiter: RTL and testbench

- Shares one external 16-bit async SRAM (RAM2 bank) between the IF-stage fetch port and the EXE-stage data port.
- Sequences the SRAM control strobes with a small FSM.
- Returns read data and one-cycle done pulses.
- Drives the pipeline hold line while a data access is pending, so the existing stall path can freeze IF/ID/EXE.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 26 ++
 rtl/mem_arbiter_tristate.sv | 30 +++
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings, widths and SRAM strobe levels for the RAM2 arbiter.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W  = 16;
  localparam int MEM_VALUE_W = 16;
  localparam int RAM_ADDR_W  = 18;

  // SRAM control strobes are all active-low
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SETUP = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_RD_LATCH = 3'd3,
    ST_WR_SETUP = 3'd4,
    ST_WR_PULSE = 3'd5,
    ST_WR_REL   = 3'd6
  } state_t;

  typedef enum logic {
    OWN_IF   = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

  function automatic logic is_read_state(state_t s);
    return s inside {ST_RD_SETUP, ST_RD_WAIT, ST_RD_LATCH};
  endfunction

  function automatic logic is_write_state(state_t s);
    return s inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_REL};
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side request/response bundle: fetch port, data port and hold line.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic                   if_req;
  logic [MEM_ADDR_W-1:0]  if_addr;
  logic [MEM_VALUE_W-1:0] if_data;
  logic                   if_done;
  logic                   d_rd;
  logic                   d_wr;
  logic [MEM_ADDR_W-1:0]  d_addr;
  logic [MEM_VALUE_W-1:0] d_wdata;
  logic [MEM_VALUE_W-1:0] d_rdata;
  logic                   d_done;
  logic                   hold;

  modport master (
    output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata,
    input  if_data, if_done, d_rdata, d_done, hold
  );

  modport slave (
    input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata,
    output if_data, if_done, d_rdata, d_done, hold
  );
endinterface

// File: rtl/mem_arbiter_tristate.sv
// Registered driver for the bidirectional SRAM data bus; the only place the bus is driven.
module mem_arbiter_tristate
  import mem_arbiter_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   drive_next,
  input  logic                   load,
  input  logic [MEM_VALUE_W-1:0] wdata,
  output logic [MEM_VALUE_W-1:0] rdata,
  inout  wire  [MEM_VALUE_W-1:0] ram_data
);

  logic                   drive_q;
  logic [MEM_VALUE_W-1:0] dout_q;

  // Reset releases the bus immediately, even mid-write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drive_q <= 1'b0;
    else     drive_q <= drive_next;
  end

  always_ff @(posedge clk) begin
    if (load) dout_q <= wdata;
  end

  assign ram_data = drive_q ? dout_q : {MEM_VALUE_W{1'bz}};
  assign rdata    = ram_data;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the RAM2 async SRAM between instruction fetch and EXE data accesses,
// sequencing the active-low strobes with a registered-output FSM.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] ADDR_HI     = 2'b00,
  parameter int         WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mem_arbiter_if.slave           bus,
  output logic [RAM_ADDR_W-1:0]  ram_addr,
  inout  wire  [MEM_VALUE_W-1:0] ram_data,
  output logic                   ram_en,
  output logic                   ram_oe,
  output logic                   ram_rw
);

  localparam logic [2:0] WAIT_RD_LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;
  localparam logic [2:0] WAIT_WR_LAST = 3'(WAIT_CYCLES);

  state_t                 state, next_state;
  owner_t                 owner;
  logic [2:0]             wait_cnt;
  logic                   grant;
  logic                   grant_data;
  logic [MEM_ADDR_W-1:0]  grant_addr;
  logic                   if_done_q, d_done_q;
  logic [MEM_VALUE_W-1:0] if_data_q, d_rdata_q;
  logic [MEM_VALUE_W-1:0] bus_rdata;

  assign grant_data = bus.d_wr | bus.d_rd;
  assign grant_addr = grant_data ? bus.d_addr : bus.if_addr;

  // No grant while a done pulse is out: that cycle is the bus turnaround and
  // the finished requester has not yet had a chance to drop its level request.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!if_done_q && !d_done_q) begin
          if (bus.d_wr) begin
            next_state = ST_WR_SETUP;
            grant      = 1'b1;
          end else if (bus.d_rd || bus.if_req) begin
            next_state = ST_RD_SETUP;
            grant      = 1'b1;
          end
        end
      end
      ST_RD_SETUP: next_state = (WAIT_CYCLES == 0) ? ST_RD_LATCH : ST_RD_WAIT;
      ST_RD_WAIT:  if (wait_cnt == WAIT_RD_LAST) next_state = ST_RD_LATCH;
      ST_RD_LATCH: next_state = ST_IDLE;
      ST_WR_SETUP: next_state = ST_WR_PULSE;
      ST_WR_PULSE: if (wait_cnt == WAIT_WR_LAST) next_state = ST_WR_REL;
      ST_WR_REL:   next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  // Strobes are registered from next_state so they change cleanly on the edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      wait_cnt  <= 3'd0;
      ram_addr  <= '0;
      ram_en    <= STROBE_OFF;
      ram_oe    <= STROBE_OFF;
      ram_rw    <= STROBE_OFF;
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      if_data_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state <= next_state;
      if ((next_state == state) && (state == ST_RD_WAIT || state == ST_WR_PULSE))
        wait_cnt <= wait_cnt + 3'd1;
      else
        wait_cnt <= 3'd0;
      if (grant) begin
        owner    <= grant_data ? OWN_DATA : OWN_IF;
        ram_addr <= {ADDR_HI, grant_addr};
      end
      ram_en <= (is_read_state(next_state) || is_write_state(next_state)) ? STROBE_ON : STROBE_OFF;
      ram_oe <= is_read_state(next_state) ? STROBE_ON : STROBE_OFF;
      ram_rw <= (next_state == ST_WR_PULSE) ? STROBE_ON : STROBE_OFF;
      if_done_q <= (state == ST_RD_LATCH) && (owner == OWN_IF);
      d_done_q  <= ((state == ST_RD_LATCH) && (owner == OWN_DATA)) || (next_state == ST_WR_REL);
      if (state == ST_RD_LATCH) begin
        if (owner == OWN_IF) if_data_q <= bus_rdata;
        else                 d_rdata_q <= bus_rdata;
      end
    end
  end

  mem_arbiter_tristate u_tri (
    .clk        (clk),
    .rst        (rst),
    .drive_next (is_write_state(next_state)),
    .load       (grant && bus.d_wr),
    .wdata      (bus.d_wdata),
    .rdata      (bus_rdata),
    .ram_data   (ram_data)
  );

  assign bus.if_data = if_data_q;
  assign bus.if_done = if_done_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_done  = d_done_q;
  assign bus.hold    = (bus.d_rd | bus.d_wr) & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scoreboard of expected done pulses plus SRAM models.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WAIT_CYCLES = 1 instance with a full behavioural SRAM
  mem_arbiter_if   bus1();
  logic [17:0]     ram1_addr;
  wire  [15:0]     ram1_data;
  logic            ram1_en, ram1_oe, ram1_rw;
  logic [15:0]     mem1 [0:262143];
  logic [15:0]     model1_q;

  mem_arbiter #(.ADDR_HI(2'b00), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .ram_addr(ram1_addr),
    .ram_data(ram1_data), .ram_en(ram1_en), .ram_oe(ram1_oe), .ram_rw(ram1_rw)
  );

  assign model1_q  = mem1[ram1_addr];
  assign ram1_data = (!ram1_en && !ram1_oe && ram1_rw) ? model1_q : 16'hzzzz;

  always @(posedge clk) begin
    if (rst) begin
      mem1[18'h00004] <= 16'h4A21;
      mem1[18'h00020] <= 16'h1234;
      mem1[18'h00000] <= 16'h1111;
      mem1[18'h00001] <= 16'h2222;
      mem1[18'h00002] <= 16'h3333;
    end else if (!ram1_en && !ram1_rw) begin
      mem1[ram1_addr] <= ram1_data;
    end
  end

  // WAIT_CYCLES = 0 instance; its SRAM returns a fixed word on every read
  mem_arbiter_if   bus0();
  logic [17:0]     ram0_addr;
  wire  [15:0]     ram0_data;
  logic            ram0_en, ram0_oe, ram0_rw;

  mem_arbiter #(.ADDR_HI(2'b00), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .ram_addr(ram0_addr),
    .ram_data(ram0_data), .ram_en(ram0_en), .ram_oe(ram0_oe), .ram_rw(ram0_rw)
  );

  assign ram0_data = (!ram0_en && !ram0_oe && ram0_rw) ? 16'h5A5A : 16'hzzzz;

  // Cumulative strobe/bus counters; the sequence compares deltas across a window
  int oe1_low = 0, rw1_low = 0, drv1_cnt = 0, wrok1_cnt = 0, oe0_low = 0, rw0_low = 0;
  always @(negedge clk) begin
    if (!ram1_oe) oe1_low <= oe1_low + 1;
    if (!ram1_rw) rw1_low <= rw1_low + 1;
    if (dut1.u_tri.drive_q) drv1_cnt <= drv1_cnt + 1;
    if (dut1.u_tri.drive_q && ram1_data === 16'hBEEF && ram1_addr === 18'h08010 && !ram1_en)
      wrok1_cnt <= wrok1_cnt + 1;
    if (!ram0_oe) oe0_low <= oe0_low + 1;
    if (!ram0_rw) rw0_low <= rw0_low + 1;
  end

  typedef struct {
    bit          is_if;
    bit          chk_data;
    logic [15:0] data;
    int          at_cyc;
  } exp_t;
  exp_t sb[$];

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_done(input string tag, input int budget);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (bus1.if_done || bus1.d_done) begin
        seen = 1'b1;
        break;
      end
    end
    check($sformatf("%s_seen", tag), 32'(seen), 32'd1);
    if (!seen) return;
    check($sformatf("%s_sb", tag), 32'(sb.size() != 0), 32'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check($sformatf("%s_kind", tag), 32'({bus1.if_done, bus1.d_done}), e.is_if ? 32'd2 : 32'd1);
    check($sformatf("%s_cycle", tag), 32'(cyc), 32'(e.at_cyc));
    if (e.chk_data)
      check($sformatf("%s_data", tag), e.is_if ? 32'(bus1.if_data) : 32'(bus1.d_rdata), 32'(e.data));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe_s, rw_s, drv_s, wrok_s, lat;
    rst = 1'b1;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_rd = 1'b0; bus1.d_wr = 1'b0;
    bus1.d_addr = '0;   bus1.d_wdata = '0;
    bus0.if_req = 1'b0; bus0.if_addr = '0; bus0.d_rd = 1'b0; bus0.d_wr = 1'b0;
    bus0.d_addr = '0;   bus0.d_wdata = '0;
    repeat (3) tick();

    check("rst_en",    32'(ram1_en), 32'd1);
    check("rst_oe",    32'(ram1_oe), 32'd1);
    check("rst_rw",    32'(ram1_rw), 32'd1);
    check("rst_addr",  32'(ram1_addr), 32'd0);
    check("rst_ifdn",  32'(bus1.if_done), 32'd0);
    check("rst_ddn",   32'(bus1.d_done), 32'd0);
    check("rst_ifdat", 32'(bus1.if_data), 32'd0);
    check("rst_drdat", 32'(bus1.d_rdata), 32'd0);
    check("rst_drive", 32'(dut1.u_tri.drive_q), 32'd0);
    check("rst_state", 32'(dut1.state), 32'(ST_IDLE));
    check("rst_hold",  32'(bus1.hold), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Single fetch
    oe_s = oe1_low; rw_s = rw1_low;
    bus1.if_addr = 16'h0004; bus1.if_req = 1'b1;
    sb.push_back('{1'b1, 1'b1, 16'h4A21, cyc + 4});
    expect_done("fetch", 10);
    bus1.if_req = 1'b0;
    check("fetch_oe_low", 32'(oe1_low - oe_s), 32'd3);
    check("fetch_rw_low", 32'(rw1_low - rw_s), 32'd0);
    check("fetch_addr",   32'(ram1_addr), 32'h00004);
    tick();

    // Data write
    oe_s = oe1_low; rw_s = rw1_low; drv_s = drv1_cnt; wrok_s = wrok1_cnt;
    bus1.d_addr = 16'h8010; bus1.d_wdata = 16'hBEEF; bus1.d_wr = 1'b1;
    #1;
    check("wr_hold_on", 32'(bus1.hold), 32'd1);
    sb.push_back('{1'b0, 1'b0, 16'h0000, cyc + 4});
    expect_done("write", 10);
    check("wr_hold_off", 32'(bus1.hold), 32'd0);
    bus1.d_wr = 1'b0;
    check("wr_rw_low",  32'(rw1_low - rw_s), 32'd2);
    check("wr_drive",   32'(drv1_cnt - drv_s), 32'd4);
    check("wr_stable",  32'(wrok1_cnt - wrok_s), 32'd4);
    check("wr_oe_low",  32'(oe1_low - oe_s), 32'd0);
    tick();
    check("wr_mem", 32'(mem1[18'h08010]), 32'hBEEF);

    // Read the written word back through the data port
    bus1.d_addr = 16'h8010; bus1.d_rd = 1'b1;
    sb.push_back('{1'b0, 1'b1, 16'hBEEF, cyc + 4});
    expect_done("rdback", 10);
    bus1.d_rd = 1'b0;
    check("rdback_addr", 32'(ram1_addr), 32'h08010);
    tick();

    // Contention: data read and fetch raised together
    bus1.d_addr = 16'h0020; bus1.d_rd = 1'b1;
    bus1.if_addr = 16'h0000; bus1.if_req = 1'b1;
    sb.push_back('{1'b0, 1'b1, 16'h1234, cyc + 4});
    sb.push_back('{1'b1, 1'b1, 16'h1111, cyc + 9});
    expect_done("cont_d", 12);
    bus1.d_rd = 1'b0;
    tick();
    check("cont_turn_en", 32'(ram1_en), 32'd1);
    check("cont_turn_if", 32'(bus1.if_done), 32'd0);
    expect_done("cont_if", 12);
    bus1.if_req = 1'b0;
    check("cont_dkeep", 32'(bus1.d_rdata), 32'h1234);
    tick();

    // Back-to-back fetches with if_req held
    drv_s = drv1_cnt; rw_s = rw1_low;
    bus1.if_addr = 16'h0000; bus1.if_req = 1'b1;
    sb.push_back('{1'b1, 1'b1, 16'h1111, cyc + 4});
    expect_done("b2b0", 10);
    bus1.if_addr = 16'h0001;
    sb.push_back('{1'b1, 1'b1, 16'h2222, cyc + 5});
    expect_done("b2b1", 10);
    bus1.if_addr = 16'h0002;
    sb.push_back('{1'b1, 1'b1, 16'h3333, cyc + 5});
    expect_done("b2b2", 10);
    bus1.if_req = 1'b0;
    check("b2b_nodrive", 32'(drv1_cnt - drv_s), 32'd0);
    check("b2b_rw_low",  32'(rw1_low - rw_s), 32'd0);
    tick();

    // Reset asserted during the write pulse
    bus1.d_addr = 16'h0040; bus1.d_wdata = 16'hCAFE; bus1.d_wr = 1'b1;
    tick(); tick();
    check("mid_pulse_rw", 32'(ram1_rw), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_rw",    32'(ram1_rw), 32'd1);
    check("mid_rst_en",    32'(ram1_en), 32'd1);
    check("mid_rst_drive", 32'(dut1.u_tri.drive_q), 32'd0);
    check("mid_rst_ddone", 32'(bus1.d_done), 32'd0);
    bus1.d_wr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("post_rst_state", 32'(dut1.state), 32'(ST_IDLE));
    bus1.if_addr = 16'h0004; bus1.if_req = 1'b1;
    sb.push_back('{1'b1, 1'b1, 16'h4A21, cyc + 4});
    expect_done("post_rst", 10);
    bus1.if_req = 1'b0;
    check("sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // WAIT_CYCLES = 0: three-cycle read, single-cycle write pulse
    oe_s = oe0_low;
    bus0.if_addr = 16'h0003; bus0.if_req = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus0.if_done) begin
        lat = i;
        break;
      end
    end
    check("w0_rd_lat",  32'(lat), 32'd3);
    check("w0_rd_data", 32'(bus0.if_data), 32'h5A5A);
    check("w0_oe_low",  32'(oe0_low - oe_s), 32'd2);
    bus0.if_req = 1'b0;
    tick();
    rw_s = rw0_low;
    bus0.d_addr = 16'h0005; bus0.d_wdata = 16'h0077; bus0.d_wr = 1'b1;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus0.d_done) begin
        lat = i;
        break;
      end
    end
    check("w0_wr_lat",   32'(lat), 32'd3);
    check("w0_hold_off", 32'(bus0.hold), 32'd0);
    bus0.d_wr = 1'b0;
    check("w0_rw_low",   32'(rw0_low - rw_s), 32'd1);
    check("w0_addr",     32'(ram0_addr), 32'h00005);
    check("w0_drdata",   32'(bus0.d_rdata), 32'd0);
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
